pc_fetch_ctrl: RTL and testbench

//  Sequencing controller for the program counter in the LEGv8 core: owns the PC register,

---
 rtl/pc_ctrl_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 25 ++
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the LEGv8 PC fetch sequencer.
// Holds the FSM state encoding and the PC stepping constants.
package pc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_EXEC  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   localparam int DEF_ADDR_W = 32;
   localparam int WORD_SHIFT = 2;
   localparam int PC_INC     = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational branch resolution and next-PC selection.
// Kept separate so a pipelined core can reuse it unchanged.
module pc_next_calc
   import pc_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] pcOffset,
   input  logic              branchFlag,
   input  logic              unconditionalBranchFlag,
   input  logic              zeroFlag,
   output logic [ADDR_W-1:0] nextPc
);

   logic take;

   // All sums are mod 2^ADDR_W; offset bits shifted past the top are dropped.
   always_comb begin
      take   = (zeroFlag & branchFlag) | unconditionalBranchFlag;
      nextPc = take ? pc + (pcOffset << WORD_SHIFT)
                    : pc + ADDR_W'(PC_INC);
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch -> issue -> execute-wait sequencer.
// Define FETCH_TIMEOUT_EN to enable the sticky fetch-timeout fault.
module pc_fetch_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                TIMEOUT_CYC  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imemReq,
   output logic [ADDR_W-1:0] imemAddr,
   input  logic              imemAck,
   input  logic [31:0]       imemData,
   output logic              instrValid,
   output logic [31:0]       instr,
   input  logic              instrReady,
   input  logic              exDone,
   input  logic              branchFlag,
   input  logic              unconditionalBranchFlag,
   input  logic              zeroFlag,
   input  logic [ADDR_W-1:0] pcOffset,
   input  logic              stall,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       retireCount,
   output logic              fault
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       retire_q, retire_d;
   logic [ADDR_W-1:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
`else
   localparam int unused_tmo = TIMEOUT_CYC;
`endif

   pc_next_calc #(
      .ADDR_W(ADDR_W)
   ) u_next (
      .pc                      (pc_q),
      .pcOffset                (pcOffset),
      .branchFlag              (branchFlag),
      .unconditionalBranchFlag (unconditionalBranchFlag),
      .zeroFlag                (zeroFlag),
      .nextPc                  (next_pc)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      retire_d = retire_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d    = cnt_q;
      fault_d  = fault_q;
`endif
      unique case (state_q)
         ST_FETCH: begin
            if (imemAck) begin
               instr_d = imemData;
               state_d = ST_ISSUE;
`ifdef FETCH_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Ack arriving on the limit cycle takes the branch above.
               state_d = ST_FAULT;
               fault_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         ST_ISSUE: begin
            if (instrReady && !stall) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (exDone && !stall) begin
               pc_d     = next_pc;
               retire_d = retire_q + 32'd1;
               state_d  = ST_FETCH;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_VECTOR;
         instr_q  <= '0;
         retire_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         retire_q <= retire_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign imemReq     = (state_q == ST_FETCH);
   assign imemAddr    = pc_q;
   assign instrValid  = (state_q == ST_ISSUE);
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign retireCount = retire_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: randomized handshakes and branches
// against a plain arithmetic PC model; monitor pops expectations on handshakes.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

   localparam int AW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          imemReq;
   logic [AW-1:0] imemAddr;
   logic          imemAck = 1'b0;
   logic [31:0]   imemData = '0;
   logic          instrValid;
   logic [31:0]   instr;
   logic          instrReady = 1'b0;
   logic          exDone = 1'b0;
   logic          branchFlag = 1'b0;
   logic          unconditionalBranchFlag = 1'b0;
   logic          zeroFlag = 1'b0;
   logic [AW-1:0] pcOffset = '0;
   logic          stall = 1'b0;
   logic [AW-1:0] pc;
   logic [31:0]   retireCount;
   logic          fault;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .ADDR_W(AW),
      .RESET_VECTOR(32'h0),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imemReq(imemReq),
      .imemAddr(imemAddr),
      .imemAck(imemAck),
      .imemData(imemData),
      .instrValid(instrValid),
      .instr(instr),
      .instrReady(instrReady),
      .exDone(exDone),
      .branchFlag(branchFlag),
      .unconditionalBranchFlag(unconditionalBranchFlag),
      .zeroFlag(zeroFlag),
      .pcOffset(pcOffset),
      .stall(stall),
      .pc(pc),
      .retireCount(retireCount),
      .fault(fault)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] ret;
   } fexp_t;

   fexp_t       fq[$];
   logic [31:0] iq[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_pc;
   logic [31:0] m_ret;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: fetch handshake carries address/retire; issue carries instr.
   always @(negedge clk) begin
      if (rst_n) begin
         if (imemReq && imemAck) begin
            if (fq.size() == 0) begin
               check("fetch_unexpected", 32'd1, 32'd0);
            end else begin
               fexp_t e;
               e = fq.pop_front();
               check("fetch_addr", imemAddr, e.addr);
               check("fetch_retire", retireCount, e.ret);
            end
         end
         if (instrValid && instrReady && !stall) begin
            if (iq.size() == 0) begin
               check("issue_unexpected", 32'd1, 32'd0);
            end else begin
               check("issue_instr", instr, iq.pop_front());
            end
         end
      end
   end

   task automatic idle();
      imemAck = 1'b0;
      instrReady = 1'b0;
      exDone = 1'b0;
      stall = 1'b0;
      branchFlag = 1'b0;
      unconditionalBranchFlag = 1'b0;
      zeroFlag = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_retire", retireCount, 32'h0);
      check("rst_valid", instrValid, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_fault", fault, 32'h0);
      fq.delete();
      iq.delete();
      m_pc = 32'h0;
      m_ret = 32'h0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_req", imemReq, 32'h1);
   endtask

   task automatic run_instr(input logic br, input logic ub, input logic z,
                            input logic [31:0] off, input int ack_dly,
                            input int rdy_dly, input int ex_dly,
                            input int stl, input bit abort);
      int n;
      fexp_t e;
      logic [31:0] d;
      logic take;
      n = 0;
      while (imemReq !== 1'b1 && n < 64) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("fetch_req", imemReq, 32'h1);
      if (imemReq !== 1'b1) return;
      for (int i = 0; i < ack_dly; i++) begin
         stall = 1'($urandom_range(0, 1));
         exDone = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      d = $urandom;
      e.addr = m_pc;
      e.ret = m_ret;
      fq.push_back(e);
      iq.push_back(d);
      imemAck = 1'b1;
      imemData = d;
      @(posedge clk);
      #1;
      imemAck = 1'b0;
      imemData = $urandom;
      stall = 1'b0;
      exDone = 1'b0;
      check("issue_valid", instrValid, 32'h1);
      for (int i = 0; i < rdy_dly; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            instrReady = 1'b1;
            stall = 1'b1;
         end else begin
            instrReady = 1'b0;
            stall = 1'($urandom_range(0, 1));
         end
         exDone = 1'($urandom_range(0, 1));
         unconditionalBranchFlag = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      instrReady = 1'b1;
      stall = 1'b0;
      exDone = 1'b0;
      @(posedge clk);
      #1;
      instrReady = 1'b0;
      unconditionalBranchFlag = 1'b0;
      check("exec_novalid", instrValid, 32'h0);
      check("exec_noreq", imemReq, 32'h0);
      if (abort) begin
         @(posedge clk);
         #2;
         do_reset();
         return;
      end
      for (int i = 0; i < ex_dly; i++) begin
         stall = 1'($urandom_range(0, 1));
         instrReady = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      instrReady = 1'b0;
      exDone = 1'b1;
      branchFlag = br;
      unconditionalBranchFlag = ub;
      zeroFlag = z;
      pcOffset = off;
      stall = (stl > 0);
      for (int i = 0; i < stl; i++) begin
         @(posedge clk);
         #1;
         check("stall_pc", pc, m_pc);
         check("stall_hold", imemReq, 32'h0);
      end
      stall = 1'b0;
      @(posedge clk);
      #1;
      idle();
      take = (br & z) | ub;
      m_pc = take ? m_pc + (off << 2) : m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
      check("retire_pc", pc, m_pc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] frz;
      logic [31:0] off;
      #2;
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("seq_pc", pc, 32'hC);
      check("seq_retire", retireCount, 32'd3);
      run_instr(0, 1, 0, 32'd13, 1, 1, 1, 0, 0);
      check("jump_40", pc, 32'h40);
      run_instr(1, 0, 1, 32'hFFFF_FFFC, 0, 2, 0, 0, 0);
      check("cbz_taken", pc, 32'h30);
      run_instr(0, 1, 0, 32'd4, 0, 0, 0, 0, 0);
      run_instr(1, 0, 0, 32'hFFFF_FFFC, 2, 0, 1, 0, 0);
      check("cbz_nottaken", pc, 32'h44);
      run_instr(0, 1, 0, 32'hFFFF_FFEE, 0, 0, 0, 0, 0);
      check("jump_top", pc, 32'hFFFF_FFFC);
      run_instr(0, 0, 0, 32'd7, 0, 0, 0, 0, 0);
      check("wrap_inc", pc, 32'h0);
      run_instr(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
      run_instr(0, 1, 0, 32'd3, 0, 0, 0, 0, 0);
      check("wrap_branch", pc, 32'h8);
      run_instr(0, 0, 0, 32'd9, 0, 0, 0, 5, 0);
      check("stall_release", pc, 32'hC);
`ifdef FETCH_TIMEOUT_EN
      run_instr(0, 0, 0, 0, TMO - 1, 0, 0, 0, 0);
      check("ack_on_limit", fault, 32'h0);
      repeat (TMO - 1) begin
         @(posedge clk);
         #1;
      end
      check("tmo_before", fault, 32'h0);
      check("tmo_req_before", imemReq, 32'h1);
      @(posedge clk);
      #1;
      check("tmo_fault", fault, 32'h1);
      check("tmo_noreq", imemReq, 32'h0);
      frz = pc;
      imemAck = 1'b1;
      instrReady = 1'b1;
      exDone = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      idle();
      check("fault_pc", pc, m_pc);
      check("fault_frozen", pc, frz);
      check("fault_sticky", fault, 32'h1);
      check("fault_novalid", instrValid, 32'h0);
      do_reset();
`else
      for (int i = 0; i < 5; i++) begin
         repeat (20) begin
            @(posedge clk);
            #1;
         end
         check("noack_fault", fault, 32'h0);
         check("noack_req", imemReq, 32'h1);
      end
`endif
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) off = $urandom;
         else off = 32'($urandom_range(0, 64)) - 32'd32;
         run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), off,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end
      check("rand_retire", retireCount, m_ret);
      run_instr(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("post_rst_pc", pc, 32'hC);
      check("post_rst_retire", retireCount, 32'd3);
      check("queues_drained", 32'(fq.size() + iq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
